// File: rtl/fe_stage_bp_pkg.sv
// Shared widths, constants and PHT counter helpers for the fetch stage.
package fe_stage_bp_pkg;

  localparam int unsigned BHR_BITS              = 8;
  localparam int unsigned BUS_CANARY_WIDTH      = 4;
  localparam int unsigned FE_latch_WIDTH        = 32 * 4 + 1 + BHR_BITS + BUS_CANARY_WIDTH;
  localparam int unsigned from_AGEX_to_FE_WIDTH = 3 + 2 * 32 + BHR_BITS;

  localparam logic [BUS_CANARY_WIDTH-1:0] BUS_CANARY_VALUE = 4'hD;

  typedef enum logic [1:0] {
    PHT_SNT = 2'b00,
    PHT_WNT = 2'b01,
    PHT_WT  = 2'b10,
    PHT_ST  = 2'b11
  } pht_ctr_e;

  localparam pht_ctr_e PHT_INIT = PHT_WNT;

  function automatic logic pht_taken(input pht_ctr_e c);
    return (c == PHT_WT) || (c == PHT_ST);
  endfunction

  // Saturating 2-bit counter step; the ends never wrap.
  function automatic pht_ctr_e pht_update(input pht_ctr_e c, input logic taken);
    pht_ctr_e n;
    n = c;
    case (c)
      PHT_SNT: n = taken ? PHT_WNT : PHT_SNT;
      PHT_WNT: n = taken ? PHT_WT  : PHT_SNT;
      PHT_WT:  n = taken ? PHT_ST  : PHT_WNT;
      PHT_ST:  n = taken ? PHT_ST  : PHT_WT;
      default: n = PHT_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fe_gshare_predictor.sv
// Gshare direction predictor plus direct-mapped BTB; owns BHR, PHT and BTB.
module fe_gshare_predictor
  import fe_stage_bp_pkg::*;
#(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned BTB_IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DBITS-1:2]    lookup_pc_i,
  output logic                pred_taken_o,
  output logic [DBITS-1:0]    pred_target_o,
  output logic [BHR_BITS-1:0] bhr_o,
  input  logic                upd_valid_i,
  input  logic                upd_taken_i,
  input  logic [DBITS-1:2]    upd_pc_i,
  input  logic [DBITS-1:0]    upd_target_i,
  input  logic [BHR_BITS-1:0] upd_old_bhr_i
);

  localparam int unsigned PHT_N = 1 << BHR_BITS;
  localparam int unsigned BTB_N = 1 << BTB_IDX_BITS;
  localparam int unsigned TAG_W = DBITS - 2 - BTB_IDX_BITS;

  pht_ctr_e            pht_q     [PHT_N];
  logic                btb_val_q [BTB_N];
  logic [TAG_W-1:0]    btb_tag_q [BTB_N];
  logic [DBITS-1:0]    btb_tgt_q [BTB_N];
  logic [BHR_BITS-1:0] bhr_q;

  logic [BHR_BITS-1:0]     lk_pht_idx, up_pht_idx;
  logic [BTB_IDX_BITS-1:0] lk_btb_idx, up_btb_idx;
  pht_ctr_e                lk_ctr;
  logic                    lk_hit;

  assign lk_pht_idx    = lookup_pc_i[BHR_BITS+1:2] ^ bhr_q;
  assign lk_btb_idx    = lookup_pc_i[BTB_IDX_BITS+1:2];
  assign lk_ctr        = pht_q[lk_pht_idx];
  assign lk_hit        = btb_val_q[lk_btb_idx] &&
                         (btb_tag_q[lk_btb_idx] == lookup_pc_i[DBITS-1:BTB_IDX_BITS+2]);
  assign pred_taken_o  = lk_hit && pht_taken(lk_ctr);
  assign pred_target_o = btb_tgt_q[lk_btb_idx];
  assign bhr_o         = bhr_q;

  assign up_pht_idx = upd_pc_i[BHR_BITS+1:2] ^ upd_old_bhr_i;
  assign up_btb_idx = upd_pc_i[BTB_IDX_BITS+1:2];

  // History is rebuilt from the resolved branch's snapshot, never speculatively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bhr_q <= '0;
      for (int unsigned i = 0; i < PHT_N; i++) pht_q[i] <= PHT_INIT;
      for (int unsigned i = 0; i < BTB_N; i++) begin
        btb_val_q[i] <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else if (upd_valid_i) begin
      pht_q[up_pht_idx] <= pht_update(pht_q[up_pht_idx], upd_taken_i);
      bhr_q             <= {upd_old_bhr_i[BHR_BITS-2:0], upd_taken_i};
      if (upd_taken_i) begin
        btb_val_q[up_btb_idx] <= 1'b1;
        btb_tag_q[up_btb_idx] <= upd_pc_i[DBITS-1:BTB_IDX_BITS+2];
        btb_tgt_q[up_btb_idx] <= upd_target_i;
      end
    end
  end

endmodule

// File: rtl/fe_stage_bp.sv
// Fetch stage: PC generation, imem access, FE latch fill and redirect/stall priority.
module fe_stage_bp
  import fe_stage_bp_pkg::*;
#(
  parameter int unsigned      DBITS        = 32,
  parameter int unsigned      BTB_IDX_BITS = 4,
  parameter logic [DBITS-1:0] START_PC     = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             from_DE_to_FE,
  input  logic [from_AGEX_to_FE_WIDTH-1:0] from_AGEX_to_FE,
  output logic [DBITS-1:0]                 imem_addr,
  input  logic [DBITS-1:0]                 imem_rdata,
  output logic [FE_latch_WIDTH-1:0]        FE_latch_out
);

  logic                br_update, br_mispred, br_taken;
  logic [DBITS-1:0]    br_pc, br_next_pc;
  logic [BHR_BITS-1:0] br_old_bhr;
  logic [1:0]          unused_br_pc_lo;

  assign {br_update, br_mispred, br_taken, br_pc, br_next_pc, br_old_bhr} = from_AGEX_to_FE;
  assign unused_br_pc_lo = br_pc[1:0];

  logic [DBITS-1:0]          pc_q, pc_d, cnt_q, cnt_d, pcplus;
  logic [FE_latch_WIDTH-1:0] latch_q, latch_d;
  logic                      pred_taken, redirect;
  logic [DBITS-1:0]          pred_target;
  logic [BHR_BITS-1:0]       bhr;

  fe_gshare_predictor #(
    .DBITS        (DBITS),
    .BTB_IDX_BITS (BTB_IDX_BITS)
  ) u_pred (
    .clk           (clk),
    .rst_n         (reset),
    .lookup_pc_i   (pc_q[DBITS-1:2]),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .bhr_o         (bhr),
    .upd_valid_i   (br_update),
    .upd_taken_i   (br_taken),
    .upd_pc_i      (br_pc[DBITS-1:2]),
    .upd_target_i  (br_next_pc),
    .upd_old_bhr_i (br_old_bhr)
  );

  assign pcplus   = pc_q + DBITS'(4);
  assign redirect = br_update && br_mispred;

  // Redirect outranks stall: the fetched word is dropped and a bubble is latched.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    if (redirect) begin
      pc_d    = br_next_pc;
      latch_d = '0;
    end else if (!from_DE_to_FE) begin
      latch_d = {imem_rdata, pc_q, pcplus, cnt_q, pred_taken, bhr, BUS_CANARY_VALUE};
      pc_d    = pred_taken ? pred_target : pcplus;
      cnt_d   = cnt_q + DBITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= START_PC;
      cnt_q   <= '0;
      latch_q <= '0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  assign imem_addr    = pc_q;
  assign FE_latch_out = latch_q;

endmodule

// File: tb/tb_fe_stage_bp.sv
// Directed bench for fe_stage_bp with a behavioural fetch/predictor model.
module tb_fe_stage_bp;
  import fe_stage_bp_pkg::*;

  localparam int LW = FE_latch_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [74:0]   agex;
  logic [31:0]   imem_addr, imem_rdata;
  logic [LW-1:0] latch;
  bit            run = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction

  assign imem_rdata = mem(imem_addr);

  fe_stage_bp dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_to_FE   (stall),
    .from_AGEX_to_FE (agex),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .FE_latch_out    (latch)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, LW'(act), LW'(exp));
  endtask

  function automatic logic [31:0] f_inst(input logic [LW-1:0] l); return l[140:109]; endfunction
  function automatic logic [31:0] f_pc  (input logic [LW-1:0] l); return l[108:77];  endfunction
  function automatic logic [31:0] f_pcp (input logic [LW-1:0] l); return l[76:45];   endfunction
  function automatic logic [31:0] f_cnt (input logic [LW-1:0] l); return l[44:13];   endfunction
  function automatic logic [31:0] f_pred(input logic [LW-1:0] l); return {31'd0, l[12]}; endfunction
  function automatic logic [31:0] f_bhr (input logic [LW-1:0] l); return {24'd0, l[11:4]}; endfunction

  // Behavioural model
  logic        br_update, br_mispred, br_taken;
  logic [31:0] br_pc, br_next_pc;
  logic [7:0]  br_old_bhr;
  assign {br_update, br_mispred, br_taken, br_pc, br_next_pc, br_old_bhr} = agex;

  logic [31:0]   m_pc, m_cnt;
  logic [7:0]    m_bhr;
  logic [LW-1:0] m_latch;
  int            m_pht  [256];
  bit            m_bv   [16];
  logic [25:0]   m_btag [16];
  logic [31:0]   m_btgt [16];

  always @(posedge clk or negedge reset) begin
    int          pidx, bidx;
    bit          hit, pred;
    logic [31:0] nxt;
    if (!reset) begin
      m_pc    = 32'h0;
      m_cnt   = 32'h0;
      m_bhr   = 8'h0;
      m_latch = '0;
      foreach (m_pht[i]) m_pht[i] = 1;
      foreach (m_bv[i])  m_bv[i]  = 1'b0;
    end else begin
      pidx = int'(m_pc[9:2] ^ m_bhr);
      bidx = int'(m_pc[5:2]);
      hit  = m_bv[bidx] && (m_btag[bidx] == m_pc[31:6]);
      pred = hit && (m_pht[pidx] >= 2);
      nxt  = pred ? m_btgt[bidx] : m_pc + 32'd4;
      if (br_update && br_mispred) begin
        m_pc    = br_next_pc;
        m_latch = '0;
      end else if (!stall) begin
        m_latch = {mem(m_pc), m_pc, m_pc + 32'd4, m_cnt, pred, m_bhr, BUS_CANARY_VALUE};
        m_pc    = nxt;
        m_cnt   = m_cnt + 32'd1;
      end
      if (br_update) begin
        pidx = int'(br_pc[9:2] ^ br_old_bhr);
        if (br_taken) m_pht[pidx] = (m_pht[pidx] == 3) ? 3 : m_pht[pidx] + 1;
        else          m_pht[pidx] = (m_pht[pidx] == 0) ? 0 : m_pht[pidx] - 1;
        m_bhr = {br_old_bhr[6:0], br_taken};
        if (br_taken) begin
          m_bv[br_pc[5:2]]   = 1'b1;
          m_btag[br_pc[5:2]] = br_pc[31:6];
          m_btgt[br_pc[5:2]] = br_next_pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model_imem_addr", LW'(imem_addr), LW'(m_pc));
      chk("model_fe_latch", latch, m_latch);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_br(input logic u, input logic m, input logic t,
                        input logic [31:0] pc, input logic [31:0] nx, input logic [7:0] bhr);
    agex = {u, m, t, pc, nx, bhr};
  endtask

  task automatic clr_br();
    agex = '0;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    agex  = '0;
    #1 run = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_latch", latch, '0);
    chk32("reset_pc", imem_addr, 32'h0);
    reset = 1'b1;

    // Sequential fetch
    tick();
    chk32("seq0_pc", f_pc(latch), 32'h0);
    chk32("seq0_inst", f_inst(latch), 32'hA500_0013);
    chk32("seq0_cnt", f_cnt(latch), 32'd0);
    chk32("seq0_pred", f_pred(latch), 32'd0);
    chk32("seq0_bhr", f_bhr(latch), 32'd0);
    tick();
    chk32("seq1_pc", f_pc(latch), 32'h4);
    chk32("seq1_cnt", f_cnt(latch), 32'd1);

    // Stall for three cycles while PC_FE = 0x8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", latch, {32'hA500_0017, 32'h4, 32'h8, 32'd1, 1'b0, 8'h00, BUS_CANARY_VALUE});
    end
    stall = 1'b0;
    tick();
    chk32("post_stall_pc", f_pc(latch), 32'h8);
    chk32("post_stall_cnt", f_cnt(latch), 32'd2);

    // Redirect together with stall
    stall = 1'b1;
    set_br(1'b1, 1'b1, 1'b0, 32'h20, 32'h100, 8'h00);
    tick();
    chk("redirect_bubble", latch, '0);
    chk32("redirect_pc", imem_addr, 32'h100);
    clr_br();
    stall = 1'b0;
    tick();
    chk32("redir_fetch_pc", f_pc(latch), 32'h100);
    chk32("redir_fetch_cnt", f_cnt(latch), 32'd3);

    // Train 0x40 -> 0x80 under history 0xFF, then redirect to 0x40
    stall = 1'b1;
    set_br(1'b1, 1'b0, 1'b1, 32'h40, 32'h80, 8'hFF);
    repeat (3) tick();
    stall = 1'b0;
    set_br(1'b1, 1'b1, 1'b1, 32'h204, 32'h40, 8'hFF);
    tick();
    chk32("train_redirect_pc", imem_addr, 32'h40);
    clr_br();
    tick();
    chk32("taken_pc", f_pc(latch), 32'h40);
    chk32("taken_pred", f_pred(latch), 32'd1);
    chk32("taken_bhr", f_bhr(latch), 32'hFF);
    chk32("taken_next", imem_addr, 32'h80);

    // Saturation at 00: four not-taken then one taken leaves weakly not-taken
    stall = 1'b1;
    set_br(1'b1, 1'b0, 1'b0, 32'h308, 32'h0, 8'hFF);
    repeat (4) tick();
    set_br(1'b1, 1'b0, 1'b1, 32'h308, 32'h400, 8'hFF);
    tick();
    stall = 1'b0;
    set_br(1'b1, 1'b1, 1'b1, 32'h204, 32'h308, 8'hFF);
    tick();
    clr_br();
    tick();
    chk32("sat_pc", f_pc(latch), 32'h308);
    chk32("sat_pred", f_pred(latch), 32'd0);
    chk32("sat_next", imem_addr, 32'h30C);
    stall = 1'b1;
    set_br(1'b1, 1'b0, 1'b1, 32'h308, 32'h400, 8'hFF);
    tick();
    stall = 1'b0;
    set_br(1'b1, 1'b1, 1'b1, 32'h204, 32'h308, 8'hFF);
    tick();
    clr_br();
    tick();
    chk32("sat_up_pred", f_pred(latch), 32'd1);
    chk32("sat_up_next", imem_addr, 32'h400);

    // Wrap of the sequential PC
    set_br(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 8'h00);
    tick();
    clr_br();
    tick();
    chk32("wrap_pc", f_pc(latch), 32'hFFFF_FFFC);
    chk32("wrap_pcplus", f_pcp(latch), 32'h0);
    chk32("wrap_next", imem_addr, 32'h0);

    // Asynchronous reset mid-cycle with stall active
    stall = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("async_latch", latch, '0);
    chk32("async_pc", imem_addr, 32'h0);
    tick();
    reset = 1'b1;
    stall = 1'b0;
    tick();
    chk32("rst_fetch_pc", f_pc(latch), 32'h0);
    chk32("rst_fetch_cnt", f_cnt(latch), 32'd0);

    // PHT trained for 0x40 via 0x44; the pre-reset BTB entry must be gone
    set_br(1'b1, 1'b1, 1'b1, 32'h44, 32'h40, 8'h00);
    repeat (3) tick();
    clr_br();
    tick();
    chk32("btb_lost_pc", f_pc(latch), 32'h40);
    chk32("btb_lost_pred", f_pred(latch), 32'd0);
    chk32("btb_lost_bhr", f_bhr(latch), 32'h01);
    chk32("btb_lost_next", imem_addr, 32'h44);

    repeat (3) tick();
    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
